sap_control_sequencer: RTL and testbench
========================================

Name: sap_control_sequencer

Overview:
- Microprogrammed control unit for the SAP-U datapath: PC, MAR, RAM, IR, A/B registers (quad D registers), 4-bit ripple/CLA adder ALU, output register.
- Steps a T-state ring (T1..T6) and decodes the IR opcode into one-hot control lines, one micro-step per clock.
- Supports free-run and single-step operation, plus a sticky HALT state.

Parameters:
- FIXED_LENGTH, 1: 1 = every instruction takes T1..T6. 0 = return to T1 after the instruction's last active micro-step.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- run  input  1  1 = advance every clock; 0 = single-step mode.
- step  input  1  single-step request, level input, rising-edge detected internally.
- opcode  input  4  IR upper nibble; must be stable from T4 to end of instruction.
- pc_inc, pc_out, pc_load  output  1 each  program counter controls.
- mar_load  output  1  load MAR from bus.
- ram_out, ram_in  output  1 each  RAM drive bus / write from bus.
- ir_load, ir_out  output  1 each  IR load; IR drives low nibble onto bus.
- a_load, a_out  output  1 each  A register controls.
- b_load  output  1  B register load.
- alu_out, alu_sub  output  1 each  adder drives bus; subtract select.
- out_load  output  1  output register load.
- halted  output  1  HALT state indicator.
- t_state  output  3  current T-state, 1..6; 0 in HALT.

Behaviour:
- Reset (reset=0, async): state=T1, step_prev=1, halted=0, t_state=1. All control outputs forced 0 combinationally while reset=0. Reset mid-instruction aborts it.
- adv = run | (step & ~step_prev); step_prev is registered every clk.
- Control outputs = decode(state, opcode) AND adv.
  - A stalled step-mode cycle asserts nothing.
  - Each advance performs exactly one micro-step.
- State advances only when adv=1; otherwise it holds.
- Fetch (all opcodes):
  - T1: pc_out, mar_load
  - T2: pc_inc
  - T3: ram_out, ir_load
- Execute (T4/T5/T6):
  - LDA 0000: T4 ir_out+mar_load; T5 ram_out+a_load; T6 none. Last active step T5.
  - ADD 0001: T4 ir_out+mar_load; T5 ram_out+b_load; T6 alu_out+a_load. Last T6.
  - SUB 0010: same as ADD, plus alu_sub in T5 and T6. Last T6.
  - STA 0100: T4 ir_out+mar_load; T5 a_out+ram_in. Last T5.
  - JMP 0110: T4 ir_out+pc_load. Last T4.
  - OUT 1110: T4 a_out+out_load. Last T4.
  - HLT 1111: T4 no outputs; the advancing edge out of T4 enters HALT.
  - Any other opcode is a NOP; last active step T4.
- Transitions:
  - T1→T2→T3→T4 unconditionally on adv.
  - From T4/T5 with FIXED_LENGTH=0 and the current step being the last active step: next state T1. Otherwise the next T-state.
  - T6→T1.
  - HLT overrides FIXED_LENGTH: T4→HALT.
- HALT:
  - halted=1, t_state=0, all control outputs 0.
  - run and step are ignored.
  - Exit only via reset.
- Step held high: exactly one advance per 0→1 transition. Step high at reset release produces no advance (step_prev resets to 1).
- run changing mid-instruction takes effect on the same cycle; the state sequence is unaffected.
- At most one bus driver is asserted in any cycle (pc_out, ram_out, ir_out, a_out, alu_out are mutually exclusive). The bench checks this as an assertion.

Test Plan:
- LDA, FIXED_LENGTH=1, run=1 after reset release:
  - Expected outputs: T1 {pc_out,mar_load}, T2 {pc_inc}, T3 {ram_out,ir_load}, T4 {ir_out,mar_load}, T5 {ram_out,a_load}, T6 {}.
  - t_state 1,2,3,4,5,6, then 1 on the 7th cycle.
- FIXED_LENGTH=0, run=1:
  - ADD takes 6 cycles.
  - JMP 0110 takes 4 cycles; pc_load in T4 only, t_state=1 on cycle 5.
  - STA takes 5 cycles, ram_in in T5 only.
- SUB: alu_sub=1 exactly in T5 and T6; alu_out+a_load in T6. Bus-driver exclusivity holds on every cycle.
- HLT 1111:
  - After the T4 edge: halted=1, t_state=0, all controls 0 for 20 cycles while run/step toggle.
  - reset pulse low → halted=0, t_state=1; fetch resumes.
- Step mode (run=0):
  - step held 1 for 5 cycles → one advance; pc_inc high for exactly one cycle in T2, no outputs during stall cycles.
  - step=1 at reset release → t_state stays 1 and no outputs until the next 0→1 transition.
- Asynchronous reset mid-T5 of ADD, between clock edges:
  - Controls drop to 0 immediately; t_state=1.
  - After release with run=1, the first cycle drives {pc_out,mar_load}.

Source files
------------

// File: rtl/sap_control_sequencer.sv
// -----------------------------------------------------------------------------
// sap_control_sequencer
//   Microprogrammed control unit for the SAP-U datapath. Walks a T-state ring
//   (T1..T6) and decodes the IR opcode into one-hot control lines, one
//   micro-step per advancing clock. Supports free-run, single-step and a
//   sticky HALT state that only reset can leave.
//
// Parameters
//   FIXED_LENGTH : 1 = every instruction runs T1..T6,
//                  0 = return to T1 after the instruction's last active step.
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   run      in   1 = advance every clock, 0 = single-step mode
//   step     in   single-step request (level, rising edge detected here)
//   opcode   in   IR upper nibble [3:0]
//   pc_inc, pc_out, pc_load, mar_load, ram_out, ram_in, ir_load, ir_out,
//   a_load, a_out, b_load, alu_out, alu_sub, out_load
//            out  datapath control strobes (valid only on advancing cycles)
//   halted   out  HALT state indicator
//   t_state  out  current T-state 1..6, 0 while halted
// -----------------------------------------------------------------------------
module sap_control_sequencer #(
  parameter bit FIXED_LENGTH = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       step,
  input  logic [3:0] opcode,
  output logic       pc_inc,
  output logic       pc_out,
  output logic       pc_load,
  output logic       mar_load,
  output logic       ram_out,
  output logic       ram_in,
  output logic       ir_load,
  output logic       ir_out,
  output logic       a_load,
  output logic       a_out,
  output logic       b_load,
  output logic       alu_out,
  output logic       alu_sub,
  output logic       out_load,
  output logic       halted,
  output logic [2:0] t_state
);

  // State encoding equals the externally visible T-state number.
  typedef enum logic [2:0] {
    S_HALT = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_T6   = 3'd6
  } state_e;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Internal control word, one bit per strobe.
  localparam logic [13:0] M_PC_INC   = 14'h2000;
  localparam logic [13:0] M_PC_OUT   = 14'h1000;
  localparam logic [13:0] M_PC_LOAD  = 14'h0800;
  localparam logic [13:0] M_MAR_LOAD = 14'h0400;
  localparam logic [13:0] M_RAM_OUT  = 14'h0200;
  localparam logic [13:0] M_RAM_IN   = 14'h0100;
  localparam logic [13:0] M_IR_LOAD  = 14'h0080;
  localparam logic [13:0] M_IR_OUT   = 14'h0040;
  localparam logic [13:0] M_A_LOAD   = 14'h0020;
  localparam logic [13:0] M_A_OUT    = 14'h0010;
  localparam logic [13:0] M_B_LOAD   = 14'h0008;
  localparam logic [13:0] M_ALU_OUT  = 14'h0004;
  localparam logic [13:0] M_ALU_SUB  = 14'h0002;
  localparam logic [13:0] M_OUT_LOAD = 14'h0001;

  state_e      state_q, state_d;
  logic        step_prev_q, step_prev_d;
  logic        adv_s;
  state_e      last_s;
  logic [13:0] dec_s;
  logic [13:0] ctl_s;

  // A stalled single-step cycle neither advances nor asserts any strobe.
  assign adv_s       = run | (step & ~step_prev_q);
  assign step_prev_d = step;

  // Last T-state that carries work for the current opcode.
  always_comb begin
    last_s = S_T4;
    case (opcode)
      OP_LDA, OP_STA: last_s = S_T5;
      OP_ADD, OP_SUB: last_s = S_T6;
      default:        last_s = S_T4;
    endcase
  end

  // Next-state logic for the T-state ring and HALT.
  always_comb begin
    state_d = state_q;
    if (adv_s) begin
      case (state_q)
        S_T1: state_d = S_T2;
        S_T2: state_d = S_T3;
        S_T3: state_d = S_T4;
        S_T4: begin
          // HLT wins over the early-return path.
          if (opcode == OP_HLT) begin
            state_d = S_HALT;
          end else if (!FIXED_LENGTH && (last_s == S_T4)) begin
            state_d = S_T1;
          end else begin
            state_d = S_T5;
          end
        end
        S_T5: begin
          if (!FIXED_LENGTH && (last_s == S_T5)) begin
            state_d = S_T1;
          end else begin
            state_d = S_T6;
          end
        end
        S_T6:   state_d = S_T1;
        S_HALT: state_d = S_HALT;
        default: state_d = S_T1;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Micro-instruction decode from (T-state, opcode).
  always_comb begin
    dec_s = 14'h0000;
    case (state_q)
      S_T1: dec_s = M_PC_OUT | M_MAR_LOAD;
      S_T2: dec_s = M_PC_INC;
      S_T3: dec_s = M_RAM_OUT | M_IR_LOAD;
      S_T4: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: dec_s = M_IR_OUT | M_MAR_LOAD;
          OP_JMP:  dec_s = M_IR_OUT | M_PC_LOAD;
          OP_OUT:  dec_s = M_A_OUT | M_OUT_LOAD;
          default: dec_s = 14'h0000;
        endcase
      end
      S_T5: begin
        case (opcode)
          OP_LDA:  dec_s = M_RAM_OUT | M_A_LOAD;
          OP_ADD:  dec_s = M_RAM_OUT | M_B_LOAD;
          OP_SUB:  dec_s = M_RAM_OUT | M_B_LOAD | M_ALU_SUB;
          OP_STA:  dec_s = M_A_OUT | M_RAM_IN;
          default: dec_s = 14'h0000;
        endcase
      end
      S_T6: begin
        case (opcode)
          OP_ADD:  dec_s = M_ALU_OUT | M_A_LOAD;
          OP_SUB:  dec_s = M_ALU_OUT | M_A_LOAD | M_ALU_SUB;
          default: dec_s = 14'h0000;
        endcase
      end
      default: dec_s = 14'h0000;
    endcase
  end

  // Gate strobes with the advance qualifier and force them low during reset.
  always_comb begin
    ctl_s = 14'h0000;
    if (adv_s && reset) begin
      ctl_s = dec_s;
    end else begin
      ctl_s = 14'h0000;
    end
  end

  // State and step-edge history registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_T1;
      step_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      step_prev_q <= step_prev_d;
    end
  end

  assign pc_inc   = ctl_s[13];
  assign pc_out   = ctl_s[12];
  assign pc_load  = ctl_s[11];
  assign mar_load = ctl_s[10];
  assign ram_out  = ctl_s[9];
  assign ram_in   = ctl_s[8];
  assign ir_load  = ctl_s[7];
  assign ir_out   = ctl_s[6];
  assign a_load   = ctl_s[5];
  assign a_out    = ctl_s[4];
  assign b_load   = ctl_s[3];
  assign alu_out  = ctl_s[2];
  assign alu_sub  = ctl_s[1];
  assign out_load = ctl_s[0];

  assign halted  = (state_q == S_HALT);
  assign t_state = state_q;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sap_control_sequencer
//   Drives one fixed-length and one variable-length sequencer with the same
//   stimulus. A table-driven instruction model predicts every cycle's strobes,
//   halted flag and T-state; directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_sap_control_sequencer;

  localparam logic [13:0] M_PC_INC   = 14'h2000;
  localparam logic [13:0] M_PC_OUT   = 14'h1000;
  localparam logic [13:0] M_PC_LOAD  = 14'h0800;
  localparam logic [13:0] M_MAR_LOAD = 14'h0400;
  localparam logic [13:0] M_RAM_OUT  = 14'h0200;
  localparam logic [13:0] M_RAM_IN   = 14'h0100;
  localparam logic [13:0] M_IR_LOAD  = 14'h0080;
  localparam logic [13:0] M_IR_OUT   = 14'h0040;
  localparam logic [13:0] M_A_LOAD   = 14'h0020;
  localparam logic [13:0] M_A_OUT    = 14'h0010;
  localparam logic [13:0] M_B_LOAD   = 14'h0008;
  localparam logic [13:0] M_ALU_OUT  = 14'h0004;
  localparam logic [13:0] M_ALU_SUB  = 14'h0002;
  localparam logic [13:0] M_OUT_LOAD = 14'h0001;
  localparam logic [13:0] M_BUS = M_PC_OUT | M_RAM_OUT | M_IR_OUT | M_A_OUT | M_ALU_OUT;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic [3:0] opcode = 4'h0;

  wire [13:0] f_ctl, v_ctl;
  wire        f_halted, v_halted;
  wire [2:0]  f_t, v_t;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // Instruction model: execute-phase strobes and number of active execute steps.
  logic [13:0] ex_tbl [16][3];
  int          ex_len [16];
  logic [2:0]  m_fix = 3'd1;
  logic [2:0]  m_var = 3'd1;
  logic        m_prev = 1'b1;

  always #5 clk = ~clk;

  sap_control_sequencer #(.FIXED_LENGTH(1'b1)) u_fix (
    .clk(clk), .reset(reset), .run(run), .step(step), .opcode(opcode),
    .pc_inc(f_ctl[13]), .pc_out(f_ctl[12]), .pc_load(f_ctl[11]), .mar_load(f_ctl[10]),
    .ram_out(f_ctl[9]), .ram_in(f_ctl[8]), .ir_load(f_ctl[7]), .ir_out(f_ctl[6]),
    .a_load(f_ctl[5]), .a_out(f_ctl[4]), .b_load(f_ctl[3]), .alu_out(f_ctl[2]),
    .alu_sub(f_ctl[1]), .out_load(f_ctl[0]), .halted(f_halted), .t_state(f_t)
  );

  sap_control_sequencer #(.FIXED_LENGTH(1'b0)) u_var (
    .clk(clk), .reset(reset), .run(run), .step(step), .opcode(opcode),
    .pc_inc(v_ctl[13]), .pc_out(v_ctl[12]), .pc_load(v_ctl[11]), .mar_load(v_ctl[10]),
    .ram_out(v_ctl[9]), .ram_in(v_ctl[8]), .ir_load(v_ctl[7]), .ir_out(v_ctl[6]),
    .a_load(v_ctl[5]), .a_out(v_ctl[4]), .b_load(v_ctl[3]), .alu_out(v_ctl[2]),
    .alu_sub(v_ctl[1]), .out_load(v_ctl[0]), .halted(v_halted), .t_state(v_t)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Strobes the model expects in T-state t for opcode opc (before adv gating).
  function automatic logic [13:0] exp_ctl(input logic [2:0] t, input logic [3:0] opc);
    if (t == 3'd1) return M_PC_OUT | M_MAR_LOAD;
    if (t == 3'd2) return M_PC_INC;
    if (t == 3'd3) return M_RAM_OUT | M_IR_LOAD;
    if (t >= 3'd4 && t <= 3'd6) return ex_tbl[opc][int'(t) - 4];
    return 14'h0000;
  endfunction

  // Full expected observation {halted, t_state, strobes}.
  function automatic logic [17:0] exp_word(input logic [2:0] t, input logic a);
    return {(t == 3'd0), t, (a ? exp_ctl(t, opcode) : 14'h0000)};
  endfunction

  // Instruction length model: fetch is 3 steps, execute ex_len, or always 6.
  function automatic logic [2:0] m_next(input logic [2:0] t, input bit fixed, input logic [3:0] opc);
    int last;
    if (t == 3'd0) return 3'd0;
    if (t == 3'd4 && opc == 4'hF) return 3'd0;
    last = fixed ? 6 : 3 + ex_len[opc];
    if (int'(t) >= last) return 3'd1;
    return t + 3'd1;
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) begin
      ex_tbl[i] = '{14'h0000, 14'h0000, 14'h0000};
      ex_len[i] = 1;
    end
    ex_tbl[0]  = '{M_IR_OUT | M_MAR_LOAD, M_RAM_OUT | M_A_LOAD, 14'h0000};
    ex_len[0]  = 2;
    ex_tbl[1]  = '{M_IR_OUT | M_MAR_LOAD, M_RAM_OUT | M_B_LOAD, M_ALU_OUT | M_A_LOAD};
    ex_len[1]  = 3;
    ex_tbl[2]  = '{M_IR_OUT | M_MAR_LOAD, M_RAM_OUT | M_B_LOAD | M_ALU_SUB,
                   M_ALU_OUT | M_A_LOAD | M_ALU_SUB};
    ex_len[2]  = 3;
    ex_tbl[4]  = '{M_IR_OUT | M_MAR_LOAD, M_A_OUT | M_RAM_IN, 14'h0000};
    ex_len[4]  = 2;
    ex_tbl[6]  = '{M_IR_OUT | M_PC_LOAD, 14'h0000, 14'h0000};
    ex_tbl[14] = '{M_A_OUT | M_OUT_LOAD, 14'h0000, 14'h0000};
  end

  // Model state update, mirroring the clock/reset behaviour of the block.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_prev <= 1'b1;
      m_fix  <= 3'd1;
      m_var  <= 3'd1;
    end else begin
      if (run | (step & ~m_prev)) begin
        m_fix <= m_next(m_fix, 1'b1, opcode);
        m_var <= m_next(m_var, 1'b0, opcode);
      end
      m_prev <= step;
    end
  end

  // Per-cycle comparison against the model plus bus-driver exclusivity.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_fix", {14'h0, f_halted, f_t, f_ctl},
          {14'h0, exp_word(m_fix, reset & (run | (step & ~m_prev)))});
      chk("model_var", {14'h0, v_halted, v_t, v_ctl},
          {14'h0, exp_word(m_var, reset & (run | (step & ~m_prev)))});
      chk("bus_excl_fix", 32'($countones(f_ctl & M_BUS) > 1), 32'd0);
      chk("bus_excl_var", 32'($countones(v_ctl & M_BUS) > 1), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic look();
    #3;
  endtask

  task automatic rst_pulse();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    logic [13:0] lda_c [7];
    logic [2:0]  lda_t [7];
    int          advs;
    lda_c = '{M_PC_OUT | M_MAR_LOAD, M_PC_INC, M_RAM_OUT | M_IR_LOAD, M_IR_OUT | M_MAR_LOAD,
              M_RAM_OUT | M_A_LOAD, 14'h0000, M_PC_OUT | M_MAR_LOAD};
    lda_t = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1};

    // Reset state
    @(posedge clk);
    #2;
    tick();
    chk_on = 1'b1;
    look();
    chk("rst_ctl", {2'b00, f_ctl, v_ctl}, 32'd0);
    chk("rst_t", {f_halted, f_t, v_halted, v_t}, 32'h11);

    // LDA, fixed length, free run
    tick();
    opcode = 4'b0000;
    run = 1'b1;
    reset = 1'b1;
    for (int k = 0; k < 7; k++) begin
      look();
      chk("lda_t", f_t, lda_t[k]);
      chk("lda_ctl", f_ctl, lda_c[k]);
      tick();
    end

    // JMP, variable length: 4 cycles, pc_load only in T4
    opcode = 4'b0110;
    rst_pulse();
    for (int k = 0; k < 5; k++) begin
      look();
      if (k == 3) chk("jmp_t4_ctl", v_ctl, M_IR_OUT | M_PC_LOAD);
      if (k == 4) chk("jmp_wrap_t", v_t, 3'd1);
      tick();
    end

    // ADD, variable length: 6 cycles
    opcode = 4'b0001;
    rst_pulse();
    for (int k = 0; k < 7; k++) begin
      look();
      if (k == 5) chk("add_t6_ctl", v_ctl, M_ALU_OUT | M_A_LOAD);
      if (k == 6) chk("add_wrap_t", v_t, 3'd1);
      tick();
    end

    // STA, variable length: 5 cycles
    opcode = 4'b0100;
    rst_pulse();
    for (int k = 0; k < 6; k++) begin
      look();
      if (k == 4) chk("sta_t5_ctl", v_ctl, M_A_OUT | M_RAM_IN);
      if (k == 5) chk("sta_wrap_t", v_t, 3'd1);
      tick();
    end

    // SUB, fixed length
    opcode = 4'b0010;
    rst_pulse();
    for (int k = 0; k < 7; k++) begin
      look();
      if (k == 3) chk("sub_t4_ctl", f_ctl, M_IR_OUT | M_MAR_LOAD);
      if (k == 4) chk("sub_t5_ctl", f_ctl, M_RAM_OUT | M_B_LOAD | M_ALU_SUB);
      if (k == 5) chk("sub_t6_ctl", f_ctl, M_ALU_OUT | M_A_LOAD | M_ALU_SUB);
      tick();
    end

    // HLT: halt after T4, inputs ignored for 20 cycles
    opcode = 4'b1111;
    rst_pulse();
    for (int k = 0; k < 4; k++) begin
      look();
      if (k == 3) chk("hlt_t4_ctl", {f_t, f_ctl}, {3'd4, 14'h0000});
      tick();
    end
    for (int k = 0; k < 20; k++) begin
      run = k[0];
      step = k[1];
      look();
      tick();
    end
    look();
    chk("hlt_state", {f_halted, f_t, v_halted, v_t}, 32'h88);
    tick();
    opcode = 4'b0000;
    run = 1'b1;
    step = 1'b0;
    rst_pulse();
    look();
    chk("hlt_exit", {f_halted, f_t, f_ctl}, {1'b0, 3'd1, M_PC_OUT | M_MAR_LOAD});
    tick();
    tick();

    // Single-step mode: step held high gives exactly one advance
    run = 1'b0;
    step = 1'b0;
    rst_pulse();
    look();
    chk("stp_idle", {f_t, f_ctl}, {3'd1, 14'h0000});
    tick();
    step = 1'b1;
    advs = 0;
    for (int k = 0; k < 5; k++) begin
      look();
      if (f_ctl != 14'h0000) advs++;
      tick();
    end
    chk("stp_one_adv", advs, 1);
    look();
    chk("stp_held_t", {f_t, f_ctl}, {3'd2, 14'h0000});
    tick();
    step = 1'b0;
    tick();
    step = 1'b1;
    look();
    chk("stp_t2_inc", {f_t, f_ctl}, {3'd2, M_PC_INC});
    tick();
    look();
    chk("stp_after_inc", {f_t, f_ctl}, {3'd3, 14'h0000});
    tick();

    // Step high at reset release: no advance until a fresh rising edge
    rst_pulse();
    for (int k = 0; k < 3; k++) begin
      look();
      chk("stp_rst_hold", {f_t, f_ctl}, {3'd1, 14'h0000});
      tick();
    end
    step = 1'b0;
    tick();
    step = 1'b1;
    look();
    chk("stp_rst_edge", f_ctl, M_PC_OUT | M_MAR_LOAD);
    tick();

    // Asynchronous reset in the middle of ADD T5
    step = 1'b0;
    run = 1'b1;
    opcode = 4'b0001;
    rst_pulse();
    repeat (4) tick();
    look();
    chk("ar_pre_ctl", f_ctl, M_RAM_OUT | M_B_LOAD);
    #1;
    reset = 1'b0;
    #1;
    chk("ar_ctl_drop", {2'b00, f_ctl, v_ctl}, 32'd0);
    chk("ar_t", {f_t, v_t}, 6'o11);
    @(posedge clk);
    #2;
    reset = 1'b1;
    look();
    chk("ar_resume", {2'b00, f_ctl, v_ctl}, {2'b00, M_PC_OUT | M_MAR_LOAD, M_PC_OUT | M_MAR_LOAD});
    tick();
    tick();
    chk_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
